// File: rtl/sqw_cmd_loader.sv
// Command loader for the two-channel square wave generator: synchronises pin writes,
// decodes header/data bytes into per-channel shadows and applies them safely. Optional readback: SQW_CMD_READBACK_EN.
module sqw_cmd_loader #(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          data_in,
    input  logic                wr_stb,
    input  logic                ch0_wrap,
    input  logic                ch1_wrap,
    output logic [PERIOD_W-1:0] ch0_half,
    output logic [PERIOD_W-1:0] ch1_half,
    output logic [1:0]          ch_en,
    output logic [1:0]          ch_pol,
    output logic [1:0]          pending,
    output logic                busy,
    output logic                err
`ifdef SQW_CMD_READBACK_EN
    ,
    input  logic [2:0]          rd_sel,
    output logic [7:0]          rd_data
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_DATA} state_t;

    logic [2:0]                 r_stb_s;
    logic [7:0]                 r_data_s1, r_data_s2;
    state_t                     r_state;
    logic                       r_ch;
    logic [1:0]                 r_addr;
    logic [TW-1:0]              r_tmo;
    logic [1:0][PERIOD_W-1:0]   r_sh_half;
    logic [1:0]                 r_sh_en, r_sh_pol;

    logic                       w_acc;
    logic                       w_hdr_ch;
    logic [2:0]                 w_hdr_addr;
    logic [1:0]                 w_arm, w_wrap, w_apply;

    // r_stb_s[1] and r_data_s2 are both two flops from the pins, so data stays aligned with the edge
    assign w_acc      = r_stb_s[1] & ~r_stb_s[2];
    assign w_hdr_ch   = r_data_s2[7];
    assign w_hdr_addr = r_data_s2[6:4];
    assign w_arm      = (r_state == IDLE && w_acc && w_hdr_addr == 3'd3) ? (2'b01 << w_hdr_ch) : 2'b00;
    assign w_wrap     = {ch1_wrap, ch0_wrap};
    // A fresh arm in the same cycle blocks the apply so the newest shadow waits for the next event
    assign w_apply    = pending & (w_wrap | ~ch_en) & ~w_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb_s   <= '0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_stb_s   <= {r_stb_s[1:0], wr_stb};
            r_data_s1 <= data_in;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ch      <= 1'b0;
            r_addr    <= '0;
            r_tmo     <= '0;
            r_sh_half <= '0;
            r_sh_en   <= '0;
            r_sh_pol  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        case (w_hdr_addr)
                            3'd0, 3'd1, 3'd2: begin
                                r_state <= WAIT_DATA;
                                busy    <= 1'b1;
                                r_ch    <= w_hdr_ch;
                                r_addr  <= w_hdr_addr[1:0];
                                r_tmo   <= TW'(TIMEOUT);
                            end
                            3'd3:    ;
                            3'd7:    err <= 1'b0;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                WAIT_DATA: begin
                    if (w_acc) begin
                        case (r_addr)
                            2'd0:    r_sh_half[r_ch][7:0]          <= r_data_s2;
                            2'd1:    r_sh_half[r_ch][PERIOD_W-1:8] <= r_data_s2[PERIOD_W-9:0];
                            default: begin
                                r_sh_en[r_ch]  <= r_data_s2[0];
                                r_sh_pol[r_ch] <= r_data_s2[1];
                            end
                        endcase
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (r_tmo == '0) begin
                        err     <= 1'b1;
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch0_half <= '0;
            ch1_half <= '0;
            ch_en    <= '0;
            ch_pol   <= '0;
            pending  <= '0;
        end else begin
            if (w_apply[0]) ch0_half <= r_sh_half[0];
            if (w_apply[1]) ch1_half <= r_sh_half[1];
            for (int n = 0; n < 2; n++) begin
                if (w_arm[n]) begin
                    pending[n] <= 1'b1;
                end else if (w_apply[n]) begin
                    pending[n] <= 1'b0;
                    ch_en[n]   <= r_sh_en[n];
                    ch_pol[n]  <= r_sh_pol[n];
                end
            end
        end
    end

`ifdef SQW_CMD_READBACK_EN
    always_comb begin
        rd_data = 8'h00;
        case (rd_sel)
            3'd0:    rd_data = ch0_half[7:0];
            3'd1:    rd_data = 8'(ch0_half >> 8);
            3'd2:    rd_data = ch1_half[7:0];
            3'd3:    rd_data = 8'(ch1_half >> 8);
            3'd4:    rd_data = {pending, ch_pol, ch_en, busy, err};
            default: rd_data = 8'h00;
        endcase
    end
`endif
endmodule

// File: tb/tb_sqw_cmd_loader.sv
// Bench for sqw_cmd_loader: directed vector table, hand-written timing corners, and
// random byte streams checked against a byte-level behavioural model.
module tb_sqw_cmd_loader;
    localparam int PW  = 16;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          wr_stb = 1'b0;
    logic          ch0_wrap = 1'b0;
    logic          ch1_wrap = 1'b0;
    logic [PW-1:0] ch0_half, ch1_half;
    logic [1:0]    ch_en, ch_pol, pending;
    logic          busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    sqw_cmd_loader #(.PERIOD_W(PW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_stb(wr_stb),
        .ch0_wrap(ch0_wrap), .ch1_wrap(ch1_wrap),
        .ch0_half(ch0_half), .ch1_half(ch1_half), .ch_en(ch_en), .ch_pol(ch_pol),
        .pending(pending), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: one call per accepted byte
    logic [15:0] m_sh_half [2];
    logic [1:0]  m_sh_en, m_sh_pol;
    logic [15:0] m_half [2];
    logic [1:0]  m_en, m_pol, m_pend;
    logic        m_err, m_wait, m_ch;
    int          m_addr;

    function automatic void model_reset();
        m_sh_half[0] = 0; m_sh_half[1] = 0; m_half[0] = 0; m_half[1] = 0;
        m_sh_en = 0; m_sh_pol = 0; m_en = 0; m_pol = 0; m_pend = 0;
        m_err = 0; m_wait = 0; m_ch = 0; m_addr = 0;
    endfunction

    function automatic void model_settle(input logic [1:0] wrapm);
        for (int n = 0; n < 2; n++) begin
            if (m_pend[n] && (wrapm[n] || !m_en[n])) begin
                m_half[n] = m_sh_half[n];
                m_en[n]   = m_sh_en[n];
                m_pol[n]  = m_sh_pol[n];
                m_pend[n] = 1'b0;
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int a;
        if (m_wait) begin
            if (m_addr == 0)      m_sh_half[m_ch] = (m_sh_half[m_ch] & 16'hFF00) | 16'(b);
            else if (m_addr == 1) m_sh_half[m_ch] = (m_sh_half[m_ch] & 16'h00FF) | (16'(b) << 8);
            else begin
                m_sh_en[m_ch]  = b[0];
                m_sh_pol[m_ch] = b[1];
            end
            m_wait = 0;
        end else begin
            a = int'(b[6:4]);
            if (a <= 2) begin
                m_wait = 1; m_ch = b[7]; m_addr = a;
            end else if (a == 3) begin
                m_pend[b[7]] = 1'b1;
                model_settle(2'b00);
            end else if (a == 7) m_err = 0;
            else m_err = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ch0_half"}, 32'(ch0_half), 32'(m_half[0]));
        chk({tag, ".ch1_half"}, 32'(ch1_half), 32'(m_half[1]));
        chk({tag, ".ch_en"},    32'(ch_en),    32'(m_en));
        chk({tag, ".ch_pol"},   32'(ch_pol),   32'(m_pol));
        chk({tag, ".pending"},  32'(pending),  32'(m_pend));
        chk({tag, ".busy"},     32'(busy),     32'(m_wait));
        chk({tag, ".err"},      32'(err),      32'(m_err));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        wr_stb  = 1'b1;
        repeat (4) @(negedge clk);
        wr_stb = 1'b0;
        repeat (4) @(negedge clk);
        model_byte(b);
    endtask

    task automatic pulse_wrap(input logic [1:0] m);
        @(negedge clk);
        {ch1_wrap, ch0_wrap} = m;
        @(negedge clk);
        {ch1_wrap, ch0_wrap} = 2'b00;
        model_settle(m);
    endtask

    typedef struct {
        logic        is_wrap;
        logic [7:0]  val;
        logic [15:0] e_h0;
        logic [1:0]  e_en;
        logic [1:0]  e_pend;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 16'd0,    2'b00, 2'b00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'hE8, 16'd0,    2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h10, 16'd0,    2'b00, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'h03, 16'd0,    2'b00, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h20, 16'd0,    2'b00, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h01, 16'd0,    2'b00, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h30, 16'd1000, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 16'd1000, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'hF4, 16'd1000, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h10, 16'd1000, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h01, 16'd1000, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h30, 16'd1000, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h01, 16'd500,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h40, 16'd500,  2'b01, 2'b00, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h70, 16'd500,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'h40, 16'd500,  2'b01, 2'b00, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h20, 16'd500,  2'b01, 2'b00, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 8'h03, 16'd500,  2'b01, 2'b00, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h70, 16'd500,  2'b01, 2'b00, 1'b0, 1'b0};

        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_wrap) pulse_wrap(tbl[i].val[1:0]);
            else                send_byte(tbl[i].val);
            chk($sformatf("vec%0d.ch0_half", i), 32'(ch0_half), 32'(tbl[i].e_h0));
            chk($sformatf("vec%0d.ch_en", i),    32'(ch_en),    32'(tbl[i].e_en));
            chk($sformatf("vec%0d.pending", i),  32'(pending),  32'(tbl[i].e_pend));
            chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(tbl[i].e_busy));
            chk($sformatf("vec%0d.err", i),      32'(err),      32'(tbl[i].e_err));
        end

        // Arm on ch0, then re-arm on the exact edge a wrap arrives: arm must win
        send_byte(8'h30);
        chk("rearm.pending_before", 32'(pending), 32'h1);
        @(negedge clk);
        data_in = 8'h30;
        wr_stb  = 1'b1;
        repeat (2) @(negedge clk);
        ch0_wrap = 1'b1;
        @(negedge clk);
        ch0_wrap = 1'b0;
        chk("collide.pending", 32'(pending), 32'h1);
        chk("collide.ch_pol",  32'(ch_pol),  32'h0);
        repeat (2) @(negedge clk);
        wr_stb = 1'b0;
        repeat (4) @(negedge clk);
        check_all("collide");
        pulse_wrap(2'b01);
        chk("collide_apply.ch_pol", 32'(ch_pol), 32'h1);
        check_all("collide_apply");

        // Header with no data byte: timeout after TMO cycles
        send_byte(8'h80);
        repeat (40) @(negedge clk);
        chk("tmo.busy_mid", 32'(busy), 32'h1);
        repeat (10) @(negedge clk);
        chk("tmo.busy_end", 32'(busy), 32'h0);
        chk("tmo.err",      32'(err),  32'h1);
        m_wait = 0; m_err = 1;
        send_byte(8'hB0);
        chk("tmo.ch1_half_unchanged", 32'(ch1_half), 32'h0);
        send_byte(8'h70);
        chk("tmo.err_cleared", 32'(err), 32'h0);
        check_all("tmo");

        // Both channels armed and enabled, wraps in the same cycle
        send_byte(8'hA0); send_byte(8'h01); send_byte(8'hB0);
        send_byte(8'h80); send_byte(8'h22); send_byte(8'hB0);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h30);
        chk("dual.pending_armed", 32'(pending), 32'h3);
        pulse_wrap(2'b11);
        chk("dual.ch0_half", 32'(ch0_half), 32'h0111);
        chk("dual.ch1_half", 32'(ch1_half), 32'h0022);
        chk("dual.pending",  32'(pending),  32'h0);
        check_all("dual");

        // Strobe held high: one accept, exactly on the third edge
        @(negedge clk);
        data_in = 8'h80;
        wr_stb  = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold.busy_edge2", 32'(busy), 32'h0);
        @(negedge clk);
        chk("hold.busy_edge3", 32'(busy), 32'h1);
        model_byte(8'h80);
        repeat (17) @(negedge clk);
        chk("hold.single_accept", 32'(busy), 32'h1);
        wr_stb = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h5A);
        send_byte(8'hB0);
        pulse_wrap(2'b10);
        chk("hold.ch1_half", 32'(ch1_half), 32'h005A);
        check_all("hold");

        // Asynchronous reset in the middle of a transaction
        send_byte(8'h40);
        send_byte(8'h00);
        chk("midrst.busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Random byte streams against the model
        for (int it = 0; it < 150; it++) begin
            if (!m_wait && $urandom_range(0, 4) == 0) begin
                pulse_wrap(2'($urandom_range(1, 3)));
                @(negedge clk);
            end else begin
                logic [7:0] b;
                int r;
                b = 8'($urandom);
                if (!m_wait) begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0, 1:    b[6:4] = 3'd0;
                        2, 3:    b[6:4] = 3'd1;
                        4:       b[6:4] = 3'd2;
                        5, 6:    b[6:4] = 3'd3;
                        7:       b[6:4] = 3'd7;
                        default: b[6:4] = 3'($urandom_range(4, 6));
                    endcase
                end
                send_byte(b);
            end
            check_all($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sqw_cmd_loader.md
Name: sqw_cmd_loader

Overview:
- Upstream configuration stage for the two-channel square wave generator.
- Receives byte commands from slow pin-driven inputs and holds per-channel half-period and control values in shadow registers.
- Transfers shadow values to the active outputs that drive the generator's counters, either on a channel's period boundary or immediately when that channel is disabled.

Parameters:
- PERIOD_W, 16: width of each channel half-period value in cycles. Legal range 9..16.
- TIMEOUT, 65535: cycles allowed between header byte and data byte before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- data_in  in  8  command/data byte, driven from pins
- wr_stb  in  1  asynchronous write strobe from a pin; a rising edge marks a valid byte
- ch0_wrap  in  1  1-cycle pulse from generator at channel 0 period boundary
- ch1_wrap  in  1  1-cycle pulse from generator at channel 1 period boundary
- ch0_half  out  PERIOD_W  active half-period, channel 0
- ch1_half  out  PERIOD_W  active half-period, channel 1
- ch_en  out  2  active enable; bit n = channel n
- ch_pol  out  2  active output polarity; bit n = channel n
- pending  out  2  shadow armed, not yet applied; bit n = channel n
- busy  out  1  high while the FSM is in WAIT_DATA
- err  out  1  sticky error flag; cleared by a write to address 7

Behaviour:
- Reset (async, rst=1):
  - ch0_half = ch1_half = 0.
  - ch_en = ch_pol = pending = 0; busy = err = 0.
  - All shadow registers = 0; FSM in IDLE; synchroniser flops = 0.
- Input path:
  - wr_stb and data_in each pass through a 2-flop synchroniser.
  - Rising edge is detected on synchronised wr_stb.
  - A byte is accepted on the third clk edge after wr_stb rises; the aligned synchronised data_in is used.
  - Only rising edges count; a held-high strobe produces exactly one accept.
- Header byte format:
  - bit7 = channel select.
  - bits6:4 = address.
  - bits3:0 ignored.
- Address map:
  - 0 = half-period bits 7:0.
  - 1 = half-period bits PERIOD_W-1:8; extra data bits are ignored.
  - 2 = control: bit0 en, bit1 pol.
  - 3 = arm; no data byte follows.
  - 7 = clear err; no data byte follows.
  - 4..6 are invalid.
- FSM, IDLE:
  - Accepted header, address 0..2 -> WAIT_DATA; latch channel and address; load timeout counter with TIMEOUT.
  - Address 3 -> set pending[ch] in the next cycle; stay IDLE.
  - Address 7 -> clear err; stay IDLE.
  - Address 4..6 -> set err; stay IDLE.
- FSM, WAIT_DATA:
  - busy=1.
  - Accepted byte -> written to the shadow field -> IDLE.
  - Timeout counter reaches 0 before a byte arrives -> set err; byte discarded -> IDLE.
- Apply rule, per channel n, evaluated every cycle:
  - If pending[n] and (chn_wrap or active ch_en[n]==0): copy shadow half/en/pol to active outputs on that edge, and clear pending[n].
  - Apply and arm in the same cycle: arm wins; pending stays 1 and the apply happens at the next qualifying event.
- Shadow writes while pending=1 are allowed. The latest shadow contents are what gets applied.
- A half-period of 0 is passed through unchanged; the generator treats 0 as stopped.
- Reset mid-transaction returns all outputs to reset values immediately; any partial header is lost.
- Channels are fully independent; simultaneous wraps apply both in the same cycle.

Optional Feature:
- Macro: SQW_CMD_READBACK_EN.
- Defined:
  - Adds output rd_data[7:0] and input rd_sel[2:0].
  - rd_data is a combinational view selected by rd_sel:
    - 0 = ch0_half[7:0]
    - 1 = ch0_half high bits
    - 2 = ch1_half[7:0]
    - 3 = ch1_half high bits
    - 4 = {pending, ch_pol, ch_en, busy, err}, zero-extended
    - 5..7 = 0
- Undefined: these ports do not exist and no readback logic is synthesised.

Test Plan:
- Reset, then write ch0: hdr 0x00/0xE8, hdr 0x10/0x03, hdr 0x20/0x01, hdr 0x30 -> ch0_half=1000 and ch_en[0]=1, applied immediately because ch0 was disabled; pending[0]=0.
- ch0 enabled; write lo=0xF4, hi=0x01, arm -> pending[0]=1 and ch0_half stays 1000 until a ch0_wrap pulse. On that pulse's edge, ch0_half=500 and pending[0]=0.
- Header 0x80 then no data for TIMEOUT cycles (bench TIMEOUT=50) -> busy drops after 50 cycles, err=1, ch1 shadow unchanged. Header 0x70 -> err=0.
- Header 0x40 (invalid address 4) -> err=1 and FSM stays IDLE. Next legal header is accepted normally.
- Arm both channels; pulse ch0_wrap and ch1_wrap in the same cycle -> both apply on the same edge. Also assert rst during WAIT_DATA -> all outputs 0 and busy=0 asynchronously.
- wr_stb held high for 20 cycles -> exactly one byte accepted, on the third edge after the rise.
